// File: rtl/acia_rx.sv
// acia_rx -- receive half of a 6551-compatible ACIA.
//
// Oversamples the serial line at 16x the bit rate, hunts for start bits,
// and deserialises 5..8 data bits LSB-first. An optional parity bit and one
// stop bit follow the data. The assembled byte and its 6551-style status
// flags are held for the register/bus-decode block.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   baud_x16     one-cycle clock enable at 16x the bit rate
//   rxd          raw serial input (idle high, asynchronous to clock)
//   word_len     00=8, 01=7, 10=6, 11=5 data bits
//   parity_en    1 = a parity bit follows the data bits
//   parity_mode  00 odd, 01 even, 10 mark, 11 space
//   rd_strobe    CPU read of the receive data register
//   data_out     last accepted byte, LSB-aligned, unused upper bits 0
//   rx_full      receive data register full
//   framing_err  stop bit of the accepted frame sampled low
//   parity_err   parity check of the accepted frame failed
//   overrun      a frame completed while the previous byte was still unread
//   rx_active    state machine is outside IDLE (activity LED)

module acia_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_x16,
  input  logic       rxd,
  input  logic [1:0] word_len,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       rd_strobe,
  output logic [7:0] data_out,
  output logic       rx_full,
  output logic       framing_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       rx_active
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  // ---------------------------------------------------------------------
  // RXD synchroniser. Resets to all ones so a reset is never mistaken for
  // a start bit on an idle line.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------
  logic [2:0] state;
  logic [3:0] cnt;       // ticks within the current bit
  logic [2:0] bitn;      // index of the next data bit
  logic [7:0] sr;        // data bits land at their own index; upper bits stay 0
  logic       par_bad;   // parity verdict of the frame in flight

  // Frame configuration, captured at the start bit so that register writes
  // during a frame only affect the next one.
  logic [1:0] cfg_wl;
  logic       cfg_pen;
  logic [1:0] cfg_pm;

  logic [2:0] last_bit;
  logic       bit_tick;   // 16 ticks after the previous sample
  logic       par_chk;
  logic       frame_done;

  // 00->7, 01->6, 10->5, 11->4
  assign last_bit = 3'd7 - {1'b0, cfg_wl};
  assign bit_tick = baud_x16 && (cnt == 4'd15);

  // Parity verdict for the bit currently on the line (used in PARITY).
  always_comb begin
    par_chk = 1'b0;
    case (cfg_pm)
      2'b00:   par_chk = ~((^sr) ^ rxd_s);  // odd: data+parity must have odd ones
      2'b01:   par_chk =  ((^sr) ^ rxd_s);  // even
      2'b10:   par_chk = ~rxd_s;            // mark: must be 1
      default: par_chk =  rxd_s;            // space: must be 0
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      bitn    <= 3'd0;
      sr      <= 8'h00;
      par_bad <= 1'b0;
      cfg_wl  <= 2'b00;
      cfg_pen <= 1'b0;
      cfg_pm  <= 2'b00;
    end else if (baud_x16) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            cnt     <= 4'd0;
            cfg_wl  <= word_len;
            cfg_pen <= parity_en;
            cfg_pm  <= parity_mode;
            state   <= START;
          end
        end

        START: begin
          cnt <= cnt + 4'd1;
          // cnt reaching 7: middle of the start bit
          if (cnt == 4'd6) begin
            if (rxd_s) begin
              state <= IDLE;        // glitch, not a start bit
            end else begin
              cnt     <= 4'd0;
              bitn    <= 3'd0;
              sr      <= 8'h00;
              par_bad <= 1'b0;
              state   <= DATA;
            end
          end
        end

        DATA: begin
          cnt <= cnt + 4'd1;        // wraps 15->0 on the sample tick
          if (cnt == 4'd15) begin
            sr[bitn] <= rxd_s;
            bitn     <= bitn + 3'd1;
            if (bitn == last_bit) state <= cfg_pen ? PARITY : STOP;
          end
        end

        PARITY: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            par_bad <= par_chk;
            state   <= STOP;
          end
        end

        STOP: begin
          cnt <= cnt + 4'd1;
          // A low stop bit is a framing error or break; hold off hunting
          // until the line returns high so a break yields one frame only.
          if (cnt == 4'd15) state <= rxd_s ? IDLE : WAIT_HIGH;
        end

        WAIT_HIGH: begin
          if (rxd_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign frame_done = bit_tick && (state == STOP);
  assign rx_active  = (state != IDLE);

  // ---------------------------------------------------------------------
  // Receive data register and status flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out    <= 8'h00;
      rx_full     <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
    end else if (frame_done && rx_full && !rd_strobe) begin
      // Unread byte still held: keep it and its flags, drop the new frame.
      overrun <= 1'b1;
    end else if (frame_done) begin
      // Either the register was empty or the CPU reads it this very cycle.
      data_out    <= sr;
      rx_full     <= 1'b1;
      framing_err <= ~rxd_s;
      parity_err  <= par_bad & cfg_pen;
      overrun     <= 1'b0;
    end else if (rd_strobe) begin
      rx_full     <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acia_rx.sv
// Self-checking bench for acia_rx: a table of single-frame vectors plus
// hand-written sequences for glitch, WAIT_HIGH, overrun, break and reset.
// baud_x16 fires every 4 clocks, so one bit time is 64 clocks.

module tb_acia_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       baud_x16 = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] word_len = 2'b00;
  logic       parity_en = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic       rd_strobe = 1'b0;
  logic [7:0] data_out;
  logic       rx_full, framing_err, parity_err, overrun, rx_active;

  int tests = 0;
  int fails = 0;
  int ph = 0;

  acia_rx #(.SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .baud_x16(baud_x16), .rxd(rxd),
    .word_len(word_len), .parity_en(parity_en), .parity_mode(parity_mode),
    .rd_strobe(rd_strobe), .data_out(data_out), .rx_full(rx_full),
    .framing_err(framing_err), .parity_err(parity_err), .overrun(overrun),
    .rx_active(rx_active)
  );

  always #5 clock = ~clock;

  // Tick phase advances on the falling edge; baud_x16 is high at every
  // rising edge that sees ph == 0.
  always @(negedge clock) begin
    ph = (ph + 1) % 4;
    baud_x16 = (ph == 0);
  end

  typedef struct {
    logic [7:0] d;
    logic [1:0] wl;
    logic       pen;
    logic [1:0] pm;
    logic       pb;
    logic       sb;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_rd();
    @(negedge clock); rd_strobe = 1'b1;
    @(negedge clock); rd_strobe = 1'b0;
  endtask

  // Return on the falling edge where rxd may drop so that the second rising
  // edge after it (when rxd_s first shows 0) is a tick.
  task automatic align();
    @(posedge clock);
    while (ph != 1) @(posedge clock);
    @(negedge clock);
  endtask

  // Send a frame starting at the current falling edge, 64 clocks per bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic pb, input logic sb, input logic keep_low);
    rxd = 1'b0;
    clocks(64);
    for (int i = 0; i < nb; i++) begin
      rxd = d[i];
      clocks(64);
    end
    if (pen) begin
      rxd = pb;
      clocks(64);
    end
    rxd = sb;
    clocks(64);
    rxd = (!sb && keep_low) ? 1'b0 : 1'b1;
  endtask

  initial begin
    //          d      wl     pen   pm     pb    sb    exp_d  fe    pe
    vecs[0] = '{8'h55, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h41, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1};
    vecs[2] = '{8'h41, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[4] = '{8'hFC, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[5] = '{8'h0A, 2'b11, 1'b1, 2'b11, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b1};
    vecs[6] = '{8'h0A, 2'b11, 1'b1, 2'b11, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b0};
    vecs[7] = '{8'h1F, 2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 8'h1F, 1'b1, 1'b0};
    vecs[8] = '{8'hFF, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};

    clocks(5);
    check("reset data_out", data_out, 8'h00);
    check("reset rx_full", rx_full, 1'b0);
    check("reset framing_err", framing_err, 1'b0);
    check("reset parity_err", parity_err, 1'b0);
    check("reset overrun", overrun, 1'b0);
    check("reset rx_active", rx_active, 1'b0);
    reset = 1'b0;
    clocks(20);

    // ---- table-driven single frames ----
    for (int v = 0; v < 9; v++) begin
      pulse_rd();
      word_len = vecs[v].wl; parity_en = vecs[v].pen; parity_mode = vecs[v].pm;
      align();
      send_frame(vecs[v].d, 8 - int'(vecs[v].wl), vecs[v].pen, vecs[v].pb, vecs[v].sb, 1'b0);
      clocks(32);
      check($sformatf("vec%0d data_out", v), data_out, vecs[v].exp_d);
      check($sformatf("vec%0d rx_full", v), rx_full, 1'b1);
      check($sformatf("vec%0d framing_err", v), framing_err, vecs[v].exp_fe);
      check($sformatf("vec%0d parity_err", v), parity_err, vecs[v].exp_pe);
      check($sformatf("vec%0d overrun", v), overrun, 1'b0);
    end

    // read alone clears flags, data holds
    pulse_rd();
    check("read rx_full", rx_full, 1'b0);
    check("read parity_err", parity_err, 1'b0);
    check("read data hold", data_out, 8'hFF);

    // ---- 4-tick low glitch: false start ----
    word_len = 2'b00; parity_en = 1'b0; parity_mode = 2'b00;
    align();
    rxd = 1'b0;
    clocks(8);
    check("glitch rx_active during", rx_active, 1'b1);
    clocks(8);
    rxd = 1'b1;
    clocks(48);
    check("glitch rx_active after", rx_active, 1'b0);
    check("glitch rx_full", rx_full, 1'b0);

    // ---- 5-bit mark parity, stop low, line held low ----
    word_len = 2'b11; parity_en = 1'b1; parity_mode = 2'b10;
    align();
    send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    check("wh data_out", data_out, 8'h1F);
    check("wh framing_err", framing_err, 1'b1);
    check("wh parity_err", parity_err, 1'b0);
    clocks(200);
    check("wh still active", rx_active, 1'b1);
    rxd = 1'b1;
    clocks(40);
    check("wh released", rx_active, 1'b0);
    check("wh overrun", overrun, 1'b0);

    // ---- overrun: two frames, no read ----
    pulse_rd();
    word_len = 2'b00; parity_en = 1'b0;
    align();
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    clocks(16);
    align();
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    clocks(16);
    check("ovr data_out", data_out, 8'h12);
    check("ovr overrun", overrun, 1'b1);
    check("ovr rx_full", rx_full, 1'b1);

    // ---- read on the stop-sample cycle: 8N1 completes 606 clocks in ----
    align();
    fork
      send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        clocks(606);
        rd_strobe = 1'b1;
        @(negedge clock);
        rd_strobe = 1'b0;
      end
    join
    clocks(16);
    check("rdsim data_out", data_out, 8'h34);
    check("rdsim rx_full", rx_full, 1'b1);
    check("rdsim overrun", overrun, 1'b0);

    // ---- break: line low for 3 frame times ----
    pulse_rd();
    align();
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    clocks(1920 - 640);
    check("brk data_out", data_out, 8'h00);
    check("brk framing_err", framing_err, 1'b1);
    check("brk rx_full", rx_full, 1'b1);
    check("brk overrun", overrun, 1'b0);
    check("brk rx_active", rx_active, 1'b1);
    rxd = 1'b1;
    clocks(40);
    check("brk released", rx_active, 1'b0);
    check("brk no 2nd frame", overrun, 1'b0);

    // ---- asynchronous reset mid-frame ----
    align();
    rxd = 1'b0;
    clocks(100);
    check("rst pre active", rx_active, 1'b1);
    reset = 1'b1;
    #1;
    check("rst rx_full", rx_full, 1'b0);
    check("rst framing_err", framing_err, 1'b0);
    check("rst data_out", data_out, 8'h00);
    check("rst rx_active", rx_active, 1'b0);
    rxd = 1'b1;
    clocks(4);
    reset = 1'b0;
    clocks(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
